// File: rtl/bsg_alu_pkg.sv
// bsg_alu_pkg
//  Shared types for the bsg_alu command path.
//  - bsg_alu_op_e : ALU opcode encoding (AND, XOR, NAND, ADD).
//  - `DECLARE_BSG_ALU_CMD_S(width) : declares bsg_alu_cmd_s {op, a, b} for a given
//    operand width. Declare it inside the module that knows the width.
//  - bsg_alu_cmd_width : packed width of a command, for flattened ports.
`ifndef BSG_ALU_PKG_SV
`define BSG_ALU_PKG_SV

`define DECLARE_BSG_ALU_CMD_S(width_mp) \
  typedef struct packed { \
    bsg_alu_op_e             op; \
    logic [(width_mp)-1:0]   a; \
    logic [(width_mp)-1:0]   b; \
  } bsg_alu_cmd_s

package bsg_alu_pkg;

  typedef enum logic [1:0] {
    e_alu_and  = 2'b00,
    e_alu_xor  = 2'b01,
    e_alu_nand = 2'b10,
    e_alu_add  = 2'b11
  } bsg_alu_op_e;

  function automatic int bsg_alu_cmd_width(input int width);
    return 2 + 2 * width;
  endfunction

endpackage

`endif

// File: rtl/bsg_alu.sv
// bsg_alu
//  Combinational ALU. Results are width_p bits; ADD wraps and drops the carry.
//  Ports:
//    op_i   in  2        opcode (bsg_alu_op_e encoding)
//    a_i    in  width_p  operand a
//    b_i    in  width_p  operand b
//    res_o  out width_p  result
module bsg_alu
  import bsg_alu_pkg::*;
#(
  parameter int width_p = 1
) (
  input  logic [1:0]         op_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (bsg_alu_op_e'(op_i))
      e_alu_and:  res_o = a_i & b_i;
      e_alu_xor:  res_o = a_i ^ b_i;
      e_alu_nand: res_o = ~(a_i & b_i);
      e_alu_add:  res_o = a_i + b_i;
      default:    res_o = '0;
    endcase
  end

endmodule

// File: rtl/bsg_alu_cmd_fifo.sv
// bsg_alu_cmd_fifo
//  els_p-deep circular command buffer, one write and one read port.
//  Ports:
//    clk_i    in  1          clock
//    reset_i  in  1          asynchronous reset, active-high (empties the buffer)
//    v_i      in  1          write request; ignored while full
//    data_i   in  cmd width  command to write (flattened bsg_alu_cmd_s)
//    full_o   out 1          no free entry
//    empty_o  out 1          no valid entry
//    data_o   out cmd width  head entry (valid when !empty_o)
//    yumi_i   in  1          pop the head; ignored while empty
module bsg_alu_cmd_fifo
  import bsg_alu_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    v_i,
  input  logic [bsg_alu_cmd_width(width_p)-1:0]   data_i,
  output logic                                    full_o,
  output logic                                    empty_o,
  output logic [bsg_alu_cmd_width(width_p)-1:0]   data_o,
  input  logic                                    yumi_i
);

  localparam int cmd_width_lp = bsg_alu_cmd_width(width_p);
  localparam int ptr_width_lp = $clog2(els_p);

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
  // differ only in the wrap bit mean full. els_p is a power of two, so a plain
  // increment wraps the index field at els_p.
  logic [ptr_width_lp:0]     r_wr_ptr;
  logic [ptr_width_lp:0]     r_rd_ptr;
  logic [cmd_width_lp-1:0]   r_mem [els_p];

  logic [ptr_width_lp-1:0]   w_wr_idx;
  logic [ptr_width_lp-1:0]   w_rd_idx;
  logic                      w_we;
  logic                      w_re;

  assign w_wr_idx = r_wr_ptr[ptr_width_lp-1:0];
  assign w_rd_idx = r_rd_ptr[ptr_width_lp-1:0];

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[ptr_width_lp] != r_rd_ptr[ptr_width_lp]) &&
                   (w_wr_idx == w_rd_idx);

  assign w_we = v_i & ~full_o;
  assign w_re = yumi_i & ~empty_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[w_wr_idx] <= data_i;
  end

  // The head is read without a register so the issue stage can load it on the
  // same edge that pops it.
  assign data_o = r_mem[w_rd_idx];

endmodule

// File: rtl/bsg_alu_issue.sv
// bsg_alu_issue
//  Command stage in front of a combinational bsg_alu. Commands are buffered,
//  issued from registers onto alu_*_o, and the ALU result is captured into an
//  output register handed off with valid/yumi. The ALU sits between two flops.
//  Ports:
//    clk_i      in  1        clock
//    reset_i    in  1        asynchronous reset, active-high; drops in-flight work
//    v_i        in  1        command valid
//    op_i       in  2        00 AND, 01 XOR, 10 NAND, 11 ADD
//    a_i, b_i   in  width_p  operands
//    ready_o    out 1        command accepted when v_i & ready_o
//    alu_op_o   out 2        registered opcode to the ALU
//    alu_a_o    out width_p  registered operand a to the ALU
//    alu_b_o    out width_p  registered operand b to the ALU
//    alu_res_i  in  width_p  ALU result (combinational from alu_*_o)
//    v_o        out 1        result valid
//    data_o     out width_p  result
//    op_o       out 2        opcode that produced data_o
//    yumi_i     in  1        consumer takes the result; only legal with v_o
//    count_o    out          commands in flight (buffer + issue + result)
module bsg_alu_issue
  import bsg_alu_pkg::*;
#(
  // Must be set by the instantiating design; 1 only keeps standalone elaboration legal.
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [1:0]                   op_i,
  input  logic [width_p-1:0]           a_i,
  input  logic [width_p-1:0]           b_i,
  output logic                         ready_o,
  output logic [1:0]                   alu_op_o,
  output logic [width_p-1:0]           alu_a_o,
  output logic [width_p-1:0]           alu_b_o,
  input  logic [width_p-1:0]           alu_res_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  output logic [1:0]                   op_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+3)-1:0]   count_o
);

  localparam int cmd_width_lp   = bsg_alu_cmd_width(width_p);
  localparam int count_width_lp = $clog2(els_p + 3);

  `DECLARE_BSG_ALU_CMD_S(width_p);

  bsg_alu_cmd_s              w_cmd_in;
  bsg_alu_cmd_s              w_head;
  logic [cmd_width_lp-1:0]   w_head_flat;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_accept;
  logic                      w_advance;
  logic                      w_pop;
  logic                      w_take;

  // Issue stage
  logic                      r_iv;
  logic [1:0]                r_alu_op;
  logic [width_p-1:0]        r_alu_a;
  logic [width_p-1:0]        r_alu_b;

  // Result stage
  logic                      r_v;
  logic [width_p-1:0]        r_data;
  logic [1:0]                r_op;

  logic [count_width_lp-1:0] r_count;

  assign w_cmd_in = '{op: bsg_alu_op_e'(op_i), a: a_i, b: b_i};
  assign w_head   = bsg_alu_cmd_s'(w_head_flat);

  // No pass-through: acceptance looks only at this cycle's full flag, so a
  // full buffer refuses input even on a cycle that also pops.
  assign w_accept  = v_i & ~w_full;
  // Both pipeline stages move together whenever the result slot is free or
  // being emptied this cycle.
  assign w_advance = ~r_v | yumi_i;
  assign w_pop     = w_advance & ~w_empty;
  assign w_take    = yumi_i & r_v;

  bsg_alu_cmd_fifo #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_accept),
    .data_i  (w_cmd_in),
    .full_o  (w_full),
    .empty_o (w_empty),
    .data_o  (w_head_flat),
    .yumi_i  (w_pop)
  );

  // Issue registers keep their last operands when idle so the ALU inputs only
  // toggle when a new command is issued.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_iv     <= 1'b0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else if (w_advance) begin
      r_iv <= ~w_empty;
      if (!w_empty) begin
        r_alu_op <= w_head.op;
        r_alu_a  <= w_head.a;
        r_alu_b  <= w_head.b;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v    <= 1'b0;
      r_data <= '0;
      r_op   <= '0;
    end else if (w_advance) begin
      r_v    <= r_iv;
      r_data <= alu_res_i;
      r_op   <= r_alu_op;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_take})
        2'b10:   r_count <= r_count + count_width_lp'(1);
        2'b01:   r_count <= r_count - count_width_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ready_o  = ~w_full;
  assign alu_op_o = r_alu_op;
  assign alu_a_o  = r_alu_a;
  assign alu_b_o  = r_alu_b;
  assign v_o      = r_v;
  assign data_o   = r_data;
  assign op_o     = r_op;
  assign count_o  = r_count;

`ifndef SYNTHESIS
  a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> r_v);
  a_op_known : assert property (@(posedge clk_i) disable iff (reset_i)
    v_i |-> !$isunknown(op_i));
`endif

endmodule

// File: tb/tb_bsg_alu_issue.sv
module tb_bsg_alu_issue;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       v_i;
  logic [1:0] op_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       ready_o;
  logic [1:0] alu_op_o;
  logic [7:0] alu_a_o;
  logic [7:0] alu_b_o;
  logic [7:0] alu_res_i;
  logic       v_o;
  logic [7:0] data_o;
  logic [1:0] op_o;
  logic       tb_yumi;
  logic       yumi_i;
  logic [2:0] count_o;

  // The consumer only takes a result that is actually offered.
  assign yumi_i = tb_yumi & v_o;

  always #5 clk = ~clk;

  bsg_alu_issue #(.width_p(8), .els_p(2)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .ready_o   (ready_o),
    .alu_op_o  (alu_op_o),
    .alu_a_o   (alu_a_o),
    .alu_b_o   (alu_b_o),
    .alu_res_i (alu_res_i),
    .v_o       (v_o),
    .data_o    (data_o),
    .op_o      (op_o),
    .yumi_i    (yumi_i),
    .count_o   (count_o)
  );

  bsg_alu #(.width_p(8)) u_alu (
    .op_i  (alu_op_o),
    .a_i   (alu_a_o),
    .b_i   (alu_b_o),
    .res_o (alu_res_i)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   m_count = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a ^ b;
      2'b10:   return ~(a & b);
      default: return a + b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with scoreboard: inputs driven #1 after the edge, outputs sampled
  // mid-cycle, accepted commands queued, taken results compared in order.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic y, output logic acc, output logic pop);
    exp_t e;
    v_i = v; op_i = op; a_i = a; b_i = b; tb_yumi = y;
    #2;
    acc = v_i & ready_o;
    pop = yumi_i;
    check("count", count_o, m_count);
    check("count_max", count_o <= 3'd4, 1);
    if (pop) begin
      check("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_data", data_o, e.d);
        check("res_op", op_o, e.op);
        $display("result op=%0d data=%02h", op_o, data_o);
      end
    end
    if (acc) exp_q.push_back('{op: op, d: alu_ref(op, a, b)});
    m_count = m_count + int'(acc) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    logic acc, pop;
    for (int i = 0; i < budget && (exp_q.size() != 0 || m_count != 0); i++)
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, acc, pop);
    check("drain_empty", exp_q.size(), 0);
    check("drain_count", count_o, 0);
    check("drain_ready", ready_o, 1);
  endtask

  // Push continuously with no consumer; returns number accepted.
  task automatic fill(input logic [7:0] b, output int n_acc);
    logic acc, pop;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 2'(i), 8'h10 + 8'(i), b, 1'b0, acc, pop);
      n_acc += int'(acc);
    end
  endtask

  initial begin : main
    logic acc, pop;
    logic [7:0] exp3 [4];
    logic [1:0] ops3 [4];
    int n_acc, sent;

    exp3[0] = 8'h88; exp3[1] = 8'h66; exp3[2] = 8'h77; exp3[3] = 8'h76;
    ops3[0] = 2'b00; ops3[1] = 2'b01; ops3[2] = 2'b10; ops3[3] = 2'b11;

    reset_i = 1'b1; v_i = 0; op_i = 0; a_i = 0; b_i = 0; tb_yumi = 0;
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_v", v_o, 0);
    check("rst_count", count_o, 0);
    check("rst_data", data_o, 0);
    check("rst_alu_a", alu_a_o, 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    repeat (3) step();
    check("idle_ready", ready_o, 1);
    check("idle_v", v_o, 0);
    check("idle_count", count_o, 0);

    // Single ADD: F0 + 25 wraps to 15, visible two edges after acceptance.
    v_i = 1; op_i = 2'b11; a_i = 8'hF0; b_i = 8'h25; tb_yumi = 1;
    step();
    v_i = 0;
    check("add_lat0", v_o, 0);
    step();
    check("add_lat1", v_o, 0);
    step();
    check("add_v", v_o, 1);
    check("add_data", data_o, 8'h15);
    check("add_op", op_o, 2'b11);
    $display("single add data=%02h op=%0d", data_o, op_o);
    step();
    check("add_gone", v_o, 0);

    // Streaming four ops on CC/AA with the consumer always ready.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        v_i = 1; op_i = ops3[k]; a_i = 8'hCC; b_i = 8'hAA;
      end else v_i = 0;
      step();
      check("stream_v", v_o, k >= 2);
      if (k >= 2) begin
        check("stream_data", data_o, exp3[k-2]);
        check("stream_op", op_o, ops3[k-2]);
        $display("stream %0d data=%02h", k - 2, data_o);
      end
    end
    step();
    check("stream_done", v_o, 0);
    check("stream_count", count_o, 0);

    // Backpressure: four in flight at most, result held while not taken.
    fill(8'h33, n_acc);
    check("bp_accepts", n_acc, 4);
    check("bp_ready", ready_o, 0);
    check("bp_count", count_o, 4);
    check("bp_v", v_o, 1);
    check("bp_data_stable", data_o, exp_q[0].d);
    $display("backpressure accepted=%0d count=%0d", n_acc, count_o);
    drain(12);

    // Full buffer plus pop in the same cycle: refused now, accepted next cycle.
    fill(8'h5A, n_acc);
    check("fp_accepts", n_acc, 4);
    cyc(1'b1, 2'b11, 8'hE1, 8'h2F, 1'b1, acc, pop);
    check("fp_refused", acc, 0);
    check("fp_popped", pop, 1);
    cyc(1'b1, 2'b11, 8'hE1, 8'h2F, 1'b0, acc, pop);
    check("fp_next_accept", acc, 1);
    $display("full+pop refused then accepted");
    drain(12);

    // Random traffic across pointer wrap.
    sent = 0;
    for (int i = 0; i < 400 && sent < 20; i++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
          8'($urandom), 1'($urandom_range(0, 1)), acc, pop);
      sent += int'(acc);
    end
    check("rand_sent", sent, 20);
    drain(40);

    // Reset with three commands in flight drops them.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 8'h40 + 8'(i), 8'h0F, 1'b0, acc, pop);
    check("mid_count_pre", count_o, 3);
    reset_i = 1; v_i = 0; tb_yumi = 0;
    #1;
    check("mid_rst_v", v_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_ready", ready_o, 1);
    step();
    reset_i = 0;
    exp_q.delete();
    m_count = 0;
    tb_yumi = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_no_late_v", v_o, 0);
    end
    check("mid_count_post", count_o, 0);
    $display("mid-stream reset dropped in-flight commands");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
